// File: rtl/mem_responder.sv
// Word-addressed single-port memory behind a valid/ready request/response handshake.
// Requests are fully serialized: capture, optional wait states, one access cycle, then hold the response.
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  // Not reset; simulation preloads it hierarchically.
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic [AW-1:0]       idx;

  assign in_range  = (addr_q < 32'(DEPTH));
  assign idx       = addr_q[AW-1:0];
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        if (WAIT_CYCLES > 0) begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
        end else begin
          state_d = ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS: begin
        valid_d = 1'b1;
        err_d   = !in_range;
        rdata_d = (in_range && !we_q) ? mem[idx] : '0;
        state_d = RESP;
      end
      RESP: if (rsp_ready) begin
        valid_d = 1'b0;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Reset forces IDLE, so a pending write never reaches this edge.
  always_ff @(posedge clk1) begin
    if (state_q == ACCESS && we_q && in_range) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a WAIT_CYCLES=2 instance (directed + random against a memory model)
// and a WAIT_CYCLES=0 instance (latency and back-to-back spacing).
module tb_mem_responder;
  localparam int WA = 2;
  localparam int DEPTH = 1024;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk1 = ~clk1;

  logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 1;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 1;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;

  mem_responder #(.DEPTH(DEPTH), .DATA_W(32), .WAIT_CYCLES(WA)) ua (
    .clk1(clk1), .rst_n(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy));

  mem_responder #(.DEPTH(DEPTH), .DATA_W(32), .WAIT_CYCLES(0)) ub (
    .clk1(clk1), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy));

  int passes = 0, checks = 0;
  logic [31:0] mdl [int unsigned];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance with rsp_ready high.
  task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int n;
    a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    n = 0;
    while (!a_req_ready && n < 50) begin tick(); n++; end
    chk({tag, " ready"}, 32'(a_req_ready), 1);
    tick();
    a_req_valid = 0; a_req_we = 1'($urandom); a_req_addr = $urandom; a_req_wdata = $urandom;
    chk({tag, " busy"}, 32'(a_busy), 1);
    chk({tag, " ready_lo"}, 32'(a_req_ready), 0);
    n = 0;
    while (!a_rsp_valid && n < 40) begin tick(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(WA + 1));
    if (addr >= DEPTH) begin
      chk({tag, " err"}, 32'(a_rsp_err), 1);
      chk({tag, " rdata"}, a_rsp_rdata, 0);
    end else if (we) begin
      chk({tag, " err"}, 32'(a_rsp_err), 0);
      chk({tag, " rdata"}, a_rsp_rdata, 0);
      mdl[addr] = wd;
    end else begin
      chk({tag, " err"}, 32'(a_rsp_err), 0);
      if (mdl.exists(addr)) chk({tag, " rdata"}, a_rsp_rdata, mdl[addr]);
    end
    tick();
    chk({tag, " done_valid"}, 32'(a_rsp_valid), 0);
    chk({tag, " done_ready"}, 32'(a_req_ready), 1);
    chk({tag, " done_busy"}, 32'(a_busy), 0);
    chk({tag, " done_rdata"}, a_rsp_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] addr;
    int sel;
    #12;
    chk("rst req_ready", 32'(a_req_ready), 1);
    chk("rst rsp_valid", 32'(a_rsp_valid), 0);
    chk("rst rsp_rdata", a_rsp_rdata, 0);
    chk("rst rsp_err", 32'(a_rsp_err), 0);
    chk("rst busy", 32'(a_busy), 0);
    chk("rst b req_ready", 32'(b_req_ready), 1);

    for (int k = 0; k < 16; k++) begin
      mdl[k] = $urandom;
      ua.mem[k] = mdl[k];
    end
    mdl[0] = 32'hA5A5A5A5; ua.mem[0] = mdl[0];
    mdl[7] = 32'h11;       ua.mem[7] = mdl[7];
    mdl[9] = 32'h99;       ua.mem[9] = mdl[9];
    mdl[1023] = 32'hC0FFEE; ua.mem[1023] = mdl[1023];
    ub.mem[3] = 32'h77;

    @(negedge clk1) rst_n = 1;
    #1;

    a_txn(1, 5, 32'hDEADBEEF, "wr5");
    a_txn(0, 5, 0, "rd5");

    // Backpressure: response held, a concurrent request must wait.
    a_rsp_ready = 0;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 5;
    tick();
    a_req_valid = 0;
    repeat (WA + 1) tick();
    chk("bp valid", 32'(a_rsp_valid), 1);
    chk("bp rdata", a_rsp_rdata, 32'hDEADBEEF);
    a_req_valid = 1; a_req_we = 0; a_req_addr = 9;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp hold valid", 32'(a_rsp_valid), 1);
      chk("bp hold rdata", a_rsp_rdata, 32'hDEADBEEF);
      chk("bp hold err", 32'(a_rsp_err), 0);
      chk("bp hold ready", 32'(a_req_ready), 0);
    end
    a_rsp_ready = 1;
    tick();
    chk("bp hs valid", 32'(a_rsp_valid), 0);
    chk("bp hs ready", 32'(a_req_ready), 1);
    tick();
    chk("bp acc9 busy", 32'(a_busy), 1);
    a_req_valid = 0;
    repeat (WA + 1) tick();
    chk("bp rd9 valid", 32'(a_rsp_valid), 1);
    chk("bp rd9 rdata", a_rsp_rdata, mdl[9]);
    tick();
    chk("bp rd9 done", 32'(a_rsp_valid), 0);

    a_txn(1, 1024, 32'h1234, "oor wr1024");
    a_txn(0, 32'hFFFFFFFF, 0, "oor rdmax");
    a_txn(0, 0, 0, "rd0");
    a_txn(0, 1023, 0, "rd1023");

    // Reset during WAIT discards the write.
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7; a_req_wdata = 32'h22;
    tick();
    a_req_valid = 0;
    tick();
    #3;
    rst_n = 0;
    #1;
    chk("rstw req_ready", 32'(a_req_ready), 1);
    chk("rstw busy", 32'(a_busy), 0);
    chk("rstw rsp_valid", 32'(a_rsp_valid), 0);
    @(negedge clk1) rst_n = 1;
    #1;
    a_txn(0, 7, 0, "rd7 after rst");

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, 15));
      else if (sel == 7) addr = 1023;
      else if (sel == 8) addr = 32'(DEPTH + $urandom_range(0, 5000));
      else               addr = {1'b1, 31'($urandom)};
      a_txn(1'($urandom_range(0, 1)), addr, $urandom, "rand");
    end

    // WAIT_CYCLES=0: one-edge latency.
    b_req_valid = 1; b_req_we = 0; b_req_addr = 3;
    tick();
    b_req_valid = 0;
    chk("b lat0 valid", 32'(b_rsp_valid), 0);
    tick();
    chk("b lat1 valid", 32'(b_rsp_valid), 1);
    chk("b lat1 rdata", b_rsp_rdata, 32'h77);
    tick();
    chk("b hs valid", 32'(b_rsp_valid), 0);
    chk("b hs ready", 32'(b_req_ready), 1);

    // Back-to-back: acceptances on relative edges 1, 4, 7.
    b_req_valid = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("b2b busy", 32'(b_busy), 32'(k % 3 != 0));
      chk("b2b valid", 32'(b_rsp_valid), 32'(k % 3 == 2));
      if (k % 3 == 2) chk("b2b rdata", b_rsp_rdata, 32'h77);
      if (k == 7) b_req_valid = 0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word-addressed memory responder for the 32-bit pipelined processor. It serves the processor's instruction-fetch and load/store accesses over a valid/ready request/response handshake, replacing the processor's internal `MEM` array. The block contains the storage array, a configurable wait-state counter and a one-entry response register. It answers every accepted request with exactly one response, for reads and writes alike, and flags out-of-range addresses.

## Interface
- DEPTH, 1024: number of 32-bit words; legal addresses are 0..DEPTH-1.
- DATA_W, 32: word width.
- WAIT_CYCLES, 2: extra access wait states, 0..15.
- clk1  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  word address; the full 32 bits are compared against DEPTH.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  address ≥ DEPTH.
- busy  output  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready, capture we/addr/wdata into internal registers.
  - If WAIT_CYCLES>0, go to WAIT with the counter set to WAIT_CYCLES. Otherwise go to ACCESS.
- WAIT
  - The counter decrements each cycle.
  - When the counter equals 1, go to ACCESS.
  - Request inputs are ignored; the captured copy is used.
- ACCESS, one cycle:
  - In range, write: array[addr] <= wdata; rsp_rdata <= 0; rsp_err <= 0.
  - In range, read: rsp_rdata <= array[addr]; rsp_err <= 0.
  - Out of range: no array access; rsp_rdata <= 0; rsp_err <= 1.
  - Set rsp_valid <= 1 and go to RESP.
- RESP
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid <= 0, rsp_rdata <= 0, rsp_err <= 0, go to IDLE.
- req_ready=0 in every state except IDLE. The requester holds its request until it is accepted.
- Read-after-write to the same address returns the new data. There is no forwarding hazard because accesses are strictly serialized.
- Reset
  - Async: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured registers=0.
  - A write not yet at its ACCESS edge is discarded.
  - Array contents are not reset. Simulation preload is by hierarchical initialization of the array.
- Reset deassertion is synchronized by the system. The first request can be accepted on the first rising edge after rst_n goes high.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Acceptance edge t0. rsp_valid rises after edge t0+WAIT_CYCLES+1.
- With rsp_ready held high, the response handshake happens on edge t0+WAIT_CYCLES+2 and req_ready returns at the same edge.
- Minimum request-to-request spacing is WAIT_CYCLES+3 cycles. For WAIT_CYCLES=0 this is 3 cycles.
- busy is high from t0 until the response handshake edge.
- rsp_ready is ignored while rsp_valid=0.
- A req_valid pulse while req_ready=0 is never captured.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle.
  - Outputs change immediately, without waiting for a clock edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
- **Write then read, WAIT_CYCLES=2, rsp_ready=1:**
  - Write addr 5 = 0xDEADBEEF: response rsp_rdata=0, err=0.
  - Read addr 5, accepted at t0: rsp_valid rises after edge t0+3 with rsp_rdata=0xDEADBEEF, err=0.
  - Next req_ready=1 after edge t0+4.
- **Backpressure:** read addr 5 with rsp_ready=0 for 4 cycles after rsp_valid.
  - rsp_valid, rsp_rdata and rsp_err stay constant throughout.
  - req_ready stays 0.
  - A concurrent req_valid with addr 9 is not accepted.
  - Once rsp_ready=1, the handshake completes and the addr 9 request is accepted on the following edge.
- **Out of range:** preload array[0]=0xA5A5A5A5.
  - Write addr 1024 data 0x1234: rsp_err=1, rsp_rdata=0.
  - Read addr 0xFFFFFFFF: rsp_err=1, rsp_rdata=0.
  - Read addr 0: returns 0xA5A5A5A5, err=0.
  - Read addr 1023: err=0.
- **Reset mid-write:** preload array[7]=0x11.
  - Issue write addr 7 = 0x22 and assert rst_n=0 during WAIT.
  - After release, read addr 7 returns 0x11.
- **WAIT_CYCLES=0 instance:**
  - Read latency is 1 edge from acceptance to rsp_valid.
  - Three back-to-back reads with req_valid and rsp_ready held high are accepted on edges t0, t0+3 and t0+6.
